// File: rtl/viewport_pixel_queue.sv
// Converts projected half-precision screen coordinates to centred integer pixels,
// drops invalid/off-screen points and queues survivors in a show-ahead FIFO.
module viewport_pixel_queue #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int COORD_W    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset_n,
  input  logic                        i_Valid,
  output logic                        o_Ready,
  input  logic [15:0]                 i_X,
  input  logic [15:0]                 i_Y,
  input  logic                        i_Exception,
  output logic                        o_PixValid,
  input  logic                        i_PixReady,
  output logic [COORD_W-1:0]          o_PixX,
  output logic [COORD_W-1:0]          o_PixY,
  output logic [15:0]                 o_DropCount,
  output logic [$clog2(FIFO_DEPTH):0] o_Count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [18:0]   HALF_W  = 19'(SCREEN_W / 2);
  localparam logic [18:0]   HALF_H  = 19'(SCREEN_H / 2);
  localparam logic [17:0]   LIM_W   = 18'(SCREEN_W);
  localparam logic [17:0]   LIM_H   = 18'(SCREEN_H);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  // Truncating half -> signed 18-bit integer; Inf/NaN handled separately as bad.
  function automatic logic [17:0] half_to_int(input logic [15:0] h);
    logic [4:0]  e;
    logic [10:0] sig;
    logic [16:0] mag;
    logic [17:0] mag18;
    e   = h[14:10];
    sig = {1'b1, h[9:0]};
    if (e < 5'd15) begin
      mag = 17'd0;
    end else if (e <= 5'd25) begin
      mag = {6'd0, sig} >> (5'd25 - e);
    end else begin
      mag = {6'd0, sig} << (e - 5'd25);
    end
    mag18 = {1'b0, mag};
    half_to_int = h[15] ? (18'd0 - mag18) : mag18;
  endfunction

  function automatic logic is_inf_nan(input logic [15:0] h);
    is_inf_nan = &h[14:10];
  endfunction

  logic                      accept;
  logic                      s1_valid, s1_bad;
  logic [17:0]               s1_vx, s1_vy;
  logic [18:0]               px, py;
  logic                      keep;
  logic                      s2_valid, s2_keep;
  logic [COORD_W-1:0]        s2_px, s2_py;
  logic [2*COORD_W-1:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]             count, count_next;
  logic                      push, pop, drop;
  logic [2*COORD_W-1:0]      head_next;

  // Credits count queued entries plus everything still in the pipeline.
  assign o_Ready    = ({1'b0, count} + (CW+1)'(s1_valid) + (CW+1)'(s2_valid)) < (CW+1)'(FIFO_DEPTH);
  assign accept     = i_Valid && o_Ready;
  assign o_Count    = count;
  assign o_PixValid = (count != CNT_ZERO);
  assign push       = s2_valid && s2_keep;
  assign drop       = s2_valid && !s2_keep;
  assign pop        = o_PixValid && i_PixReady;

  // Stage 1: decode both coordinates at the accept edge.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      s1_valid <= 1'b0;
      s1_bad   <= 1'b0;
      s1_vx    <= 18'd0;
      s1_vy    <= 18'd0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_bad <= is_inf_nan(i_X) || is_inf_nan(i_Y) || i_Exception;
        s1_vx  <= half_to_int(i_X);
        s1_vy  <= half_to_int(i_Y);
      end
    end
  end

  // Screen rows grow downward, so Y is subtracted from the centre row.
  assign px   = {s1_vx[17], s1_vx} + HALF_W;
  assign py   = HALF_H - {s1_vy[17], s1_vy};
  assign keep = !s1_bad && !px[18] && (px[17:0] < LIM_W) && !py[18] && (py[17:0] < LIM_H);

  // Stage 2: on-screen classification.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      s2_valid <= 1'b0;
      s2_keep  <= 1'b0;
      s2_px    <= {COORD_W{1'b0}};
      s2_py    <= {COORD_W{1'b0}};
    end else begin
      s2_valid <= s1_valid;
      s2_keep  <= keep;
      s2_px    <= px[COORD_W-1:0];
      s2_py    <= py[COORD_W-1:0];
    end
  end

  // Next head: bypass the incoming entry when it lands in the slot being exposed.
  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
    if (pop) begin
      rd_next = rd_ptr + PTR_ONE;
    end else begin
      rd_next = rd_ptr;
    end
    if (count_next == CNT_ZERO) begin
      head_next = {o_PixX, o_PixY};
    end else if (push && (wr_ptr == rd_next)) begin
      head_next = {s2_px, s2_py};
    end else begin
      head_next = mem[rd_next];
    end
  end

  // FIFO storage write port.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem[wr_ptr] <= {s2_px, s2_py};
    end
  end

  // FIFO pointers, occupancy and registered head.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= CNT_ZERO;
      o_PixX <= {COORD_W{1'b0}};
      o_PixY <= {COORD_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr           <= rd_next;
      count            <= count_next;
      {o_PixX, o_PixY} <= head_next;
    end
  end

  // Saturating discard counter.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_DropCount <= 16'd0;
    end else if (drop && (o_DropCount != 16'hFFFF)) begin
      o_DropCount <= o_DropCount + 16'd1;
    end
  end
endmodule

// File: tb/tb_viewport_pixel_queue.sv
// Directed self-checking bench for viewport_pixel_queue with hand-computed pixels.
module tb_viewport_pixel_queue;
  logic        i_Clk = 1'b0;
  logic        i_Reset_n = 1'b0;
  logic        i_Valid = 1'b0;
  logic        i_Exception = 1'b0;
  logic        i_PixReady = 1'b0;
  logic [15:0] i_X = 16'h0000;
  logic [15:0] i_Y = 16'h0000;
  logic        o_Ready, o_PixValid;
  logic [9:0]  o_PixX, o_PixY;
  logic [15:0] o_DropCount;
  logic [2:0]  o_Count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_total = 0;
  logic [15:0] src_x[$];
  logic [9:0]  got_x[$];
  // Halves 1..8 -> px 321..328 with Y=0 (py 240)
  logic [15:0] ramp [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                            16'h4500, 16'h4600, 16'h4700, 16'h4800};

  viewport_pixel_queue dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_X(i_X), .i_Y(i_Y), .i_Exception(i_Exception), .o_PixValid(o_PixValid),
    .i_PixReady(i_PixReady), .o_PixX(o_PixX), .o_PixY(o_PixY),
    .o_DropCount(o_DropCount), .o_Count(o_Count)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic exc);
    i_Valid = 1'b1; i_X = x; i_Y = y; i_Exception = exc;
    tick();
    i_Valid = 1'b0; i_Exception = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [9:0] ex, input logic [9:0] ey);
    check_eq({tag, "_valid"}, o_PixValid, 1);
    check_eq({tag, "_x"}, o_PixX, ex);
    check_eq({tag, "_y"}, o_PixY, ey);
    i_PixReady = 1'b1;
    tick();
    i_PixReady = 1'b0;
  endtask

  // Drives src_x as a continuous source (Y=0) and logs popped columns.
  task automatic stream(input logic pix_ready, input int cycles, input logic chk_gap);
    for (int c = 0; c < cycles; c++) begin
      i_PixReady = pix_ready;
      i_Valid    = (src_x.size() > 0);
      i_X        = (src_x.size() > 0) ? src_x[0] : 16'h0000;
      i_Y        = 16'h0000;
      if (chk_gap && got_x.size() < n_total) check_eq("no_gap", o_PixValid, 1);
      if (pix_ready && o_PixValid) got_x.push_back(o_PixX);
      if (i_Valid && o_Ready) void'(src_x.pop_front());
      tick();
    end
    i_Valid = 1'b0;
    i_PixReady = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    check_eq("rst_valid", o_PixValid, 0);
    check_eq("rst_x", o_PixX, 0);
    check_eq("rst_y", o_PixY, 0);
    check_eq("rst_drop", o_DropCount, 0);
    check_eq("rst_count", o_Count, 0);
    i_Reset_n = 1'b1;
    check_eq("rst_ready", o_Ready, 1);

    // Origin point, two-cycle latency
    send(16'h0000, 16'h0000, 1'b0);
    check_eq("lat_n0", o_PixValid, 0);
    tick();
    check_eq("lat_n1", o_PixValid, 0);
    tick();
    pop_check("origin", 10'd320, 10'd240);
    check_eq("origin_cnt", o_Count, 0);
    check_eq("origin_empty", o_PixValid, 0);
    check_eq("hold_x", o_PixX, 320);

    // Conversion and sign
    send(16'h5140, 16'hD140, 1'b0);
    send(16'h3BFF, 16'h5B80, 1'b0);
    send(16'hDD00, 16'h0000, 1'b0);
    tick(); tick();
    check_eq("conv_cnt", o_Count, 3);
    pop_check("p42", 10'd362, 10'd282);
    pop_check("top", 10'd320, 10'd0);
    pop_check("left", 10'd0, 10'd240);
    check_eq("conv_drop", o_DropCount, 0);

    // Drops
    send(16'h5D00, 16'h0000, 1'b0);
    send(16'h0000, 16'hDB80, 1'b0);
    send(16'h7C00, 16'h0000, 1'b0);
    tick(); tick();
    check_eq("drop3", o_DropCount, 3);
    check_eq("drop3_cnt", o_Count, 0);
    send(16'h0000, 16'h0000, 1'b1);
    tick(); tick();
    check_eq("drop_exc", o_DropCount, 4);
    check_eq("drop_exc_cnt", o_Count, 0);
    check_eq("drop_exc_valid", o_PixValid, 0);

    // Backpressure: only four credits
    for (int i = 0; i < 6; i++) src_x.push_back(ramp[i]);
    stream(1'b0, 8, 1'b0);
    check_eq("bp_accepted", 6 - src_x.size(), 4);
    check_eq("bp_ready", o_Ready, 0);
    check_eq("bp_count", o_Count, 4);
    got_x.delete();
    stream(1'b1, 16, 1'b0);
    check_eq("bp_out_n", got_x.size(), 6);
    for (int i = 0; i < 6; i++) check_eq($sformatf("bp_order%0d", i), got_x[i], 321 + i);
    check_eq("bp_drain", o_Count, 0);

    // Simultaneous push/pop at count 2, then continuous traffic
    got_x.delete();
    n_total = 8;
    for (int i = 0; i < 3; i++) src_x.push_back(ramp[i]);
    stream(1'b0, 4, 1'b0);
    check_eq("pp_pre_cnt", o_Count, 2);
    for (int i = 3; i < 8; i++) src_x.push_back(ramp[i]);
    stream(1'b1, 1, 1'b0);
    check_eq("pp_cnt", o_Count, 2);
    stream(1'b1, 20, 1'b1);
    check_eq("pp_out_n", got_x.size(), 8);
    for (int i = 0; i < 8; i++) check_eq($sformatf("pp_order%0d", i), got_x[i], 321 + i);
    check_eq("pp_drain", o_Count, 0);

    // Reset mid-stream: two queued, two in flight
    for (int i = 0; i < 4; i++) src_x.push_back(ramp[i]);
    stream(1'b0, 4, 1'b0);
    check_eq("mr_pre_cnt", o_Count, 2);
    i_Reset_n = 1'b0;
    #1;
    check_eq("mr_valid", o_PixValid, 0);
    check_eq("mr_x", o_PixX, 0);
    check_eq("mr_y", o_PixY, 0);
    check_eq("mr_drop", o_DropCount, 0);
    check_eq("mr_count", o_Count, 0);
    check_eq("mr_ready", o_Ready, 1);
    tick();
    i_Reset_n = 1'b1;
    tick(); tick(); tick(); tick();
    check_eq("post_valid", o_PixValid, 0);
    check_eq("post_count", o_Count, 0);
    check_eq("post_drop", o_DropCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
